// File: rtl/bus_matrix_firewall.sv
// Programmable address decoder and security firewall for one bus-matrix master port.
// Region hits are evaluated in parallel; the lowest-index hit owns the access attributes.

module bus_matrix_firewall_region #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  enable,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH-1:0] end_addr,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic                  hit
);
  // An inverted window (start > end) can never satisfy both bounds.
  assign hit = enable && (addr >= start_addr) && (addr <= end_addr);
endmodule

module bus_matrix_firewall #(
  parameter int M_SLAVES   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int N_REGIONS  = 8,
  localparam int SIDX_W    = (M_SLAVES > 1) ? $clog2(M_SLAVES) : 1,
  localparam int RIDX_W    = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1,
  localparam int RW        = 2*ADDR_WIDTH + SIDX_W + 3,
  parameter logic [N_REGIONS*RW-1:0] RESET_MAP_FLAT = '0,
  parameter bit USE_DEFAULT_SLAVE   = 1'b0,
  parameter int DEFAULT_SLAVE_INDEX = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic                  req_secure_i,
  input  logic                  req_write_i,
  output logic                  dec_valid_o,
  input  logic                  dec_ready_i,
  output logic [M_SLAVES-1:0]   dec_slave_sel_o,
  output logic                  dec_error_o,
  output logic                  sec_error_o,
  output logic                  prot_error_o,
  input  logic                  cfg_we_i,
  input  logic [RIDX_W-1:0]     cfg_region_i,
  input  logic [RW-1:0]         cfg_wdata_i,
  output logic [RW-1:0]         cfg_rdata_o,
  input  logic                  cfg_lock_i,
  output logic                  cfg_locked_o,
  output logic                  cfg_err_o,
  output logic                  fault_valid_o,
  output logic                  fault_overflow_o,
  output logic [ADDR_WIDTH-1:0] fault_addr_o,
  output logic [1:0]            fault_type_o,
  output logic                  fault_secure_o,
  output logic                  fault_write_o,
  input  logic                  fault_clr_i
);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] start_addr;
    logic [ADDR_WIDTH-1:0] end_addr;
    logic [SIDX_W-1:0]     slave;
    logic                  write_allowed;
    logic                  secure;
    logic                  enable;
  } region_t;

  typedef struct packed {
    logic [M_SLAVES-1:0] sel;
    logic                dec_err;
    logic                sec_err;
    logic                prot_err;
  } dec_rsp_t;

  region_t [N_REGIONS-1:0] map;
  logic    [N_REGIONS-1:0] hit;

  for (genvar r = 0; r < N_REGIONS; r++) begin : g_rgn
    bus_matrix_firewall_region #(.ADDR_WIDTH(ADDR_WIDTH)) u_rgn (
      .enable     (map[r].enable),
      .start_addr (map[r].start_addr),
      .end_addr   (map[r].end_addr),
      .addr       (req_addr_i),
      .hit        (hit[r])
    );
  end

  logic              hit_any;
  logic              win_secure;
  logic              win_wa;
  logic [SIDX_W-1:0] win_slave;

  // Walk high to low so the lowest-index hit is the last one written.
  always_comb begin
    hit_any    = 1'b0;
    win_secure = 1'b0;
    win_wa     = 1'b0;
    win_slave  = '0;
    for (int r = N_REGIONS-1; r >= 0; r--) begin
      if (hit[r]) begin
        hit_any    = 1'b1;
        win_secure = map[r].secure;
        win_wa     = map[r].write_allowed;
        win_slave  = map[r].slave;
      end
    end
  end

  dec_rsp_t rsp_d;

  always_comb begin
    rsp_d = '0;
    if (hit_any) begin
      if (win_secure && !req_secure_i)    rsp_d.sec_err  = 1'b1;
      else if (req_write_i && !win_wa)    rsp_d.prot_err = 1'b1;
      else                                rsp_d.sel      = M_SLAVES'(1) << win_slave;
    end else if (USE_DEFAULT_SLAVE) begin
      rsp_d.sel[DEFAULT_SLAVE_INDEX] = 1'b1;
    end else begin
      rsp_d.dec_err = 1'b1;
    end
  end

  logic       accept;
  logic       new_fault;
  logic [1:0] fault_type_d;

  assign req_ready_o  = !dec_valid_o || dec_ready_i;
  assign accept       = req_valid_i && req_ready_o;
  assign new_fault    = accept && (rsp_d.dec_err || rsp_d.sec_err || rsp_d.prot_err);
  assign fault_type_d = rsp_d.dec_err ? 2'b01 : (rsp_d.sec_err ? 2'b10 : 2'b11);

  dec_rsp_t rsp_q;

  assign dec_slave_sel_o = rsp_q.sel;
  assign dec_error_o     = rsp_q.dec_err;
  assign sec_error_o     = rsp_q.sec_err;
  assign prot_error_o    = rsp_q.prot_err;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dec_valid_o      <= 1'b0;
      rsp_q            <= '0;
      fault_valid_o    <= 1'b0;
      fault_overflow_o <= 1'b0;
      fault_addr_o     <= '0;
      fault_type_o     <= 2'b00;
      fault_secure_o   <= 1'b0;
      fault_write_o    <= 1'b0;
    end else begin
      if (req_ready_o) begin
        dec_valid_o <= req_valid_i;
        rsp_q       <= req_valid_i ? rsp_d : '0;
      end
      // A clear in the same cycle as a new fault frees the slot for that fault.
      if (new_fault) begin
        if (!fault_valid_o || fault_clr_i) begin
          fault_valid_o    <= 1'b1;
          fault_overflow_o <= 1'b0;
          fault_addr_o     <= req_addr_i;
          fault_type_o     <= fault_type_d;
          fault_secure_o   <= req_secure_i;
          fault_write_o    <= req_write_i;
        end else begin
          fault_overflow_o <= 1'b1;
        end
      end else if (fault_clr_i) begin
        fault_valid_o    <= 1'b0;
        fault_overflow_o <= 1'b0;
      end
    end
  end

  logic cfg_in_range;
  logic cfg_wr_ok;

  assign cfg_in_range = ({1'b0, cfg_region_i} < (RIDX_W+1)'(N_REGIONS));
  assign cfg_wr_ok    = cfg_we_i && !cfg_locked_o && cfg_in_range;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      map          <= RESET_MAP_FLAT;
      cfg_locked_o <= 1'b0;
      cfg_err_o    <= 1'b0;
    end else begin
      cfg_err_o <= cfg_we_i && !cfg_wr_ok;
      if (cfg_lock_i) cfg_locked_o <= 1'b1;
      for (int r = 0; r < N_REGIONS; r++) begin
        if (cfg_wr_ok && (cfg_region_i == RIDX_W'(r))) map[r] <= cfg_wdata_i;
      end
    end
  end

  always_comb begin
    cfg_rdata_o = '0;
    for (int r = 0; r < N_REGIONS; r++) begin
      if (cfg_region_i == RIDX_W'(r)) cfg_rdata_o = map[r];
    end
  end

endmodule
